// File: rtl/uart_tx_arbiter_if.sv
// Requester byte handshake plus uart register-write and status bundle for uart_tx_arbiter.
// master = arbiter side, slave = requesters/uart side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   grant;
  logic [7:0]           reg_data_out;
  logic                 spbrg_reg_wr_en;
  logic                 txsta_reg_wr_en;
  logic                 txreg_reg_wr_en;
  logic                 txif;
  logic                 trmt;
  logic                 cfg_done;
  logic                 busy;
  logic                 timeout_pulse;

  modport master (
    input  req_valid, req_data, req_last, txif, trmt,
    output req_ready, grant, reg_data_out, spbrg_reg_wr_en, txsta_reg_wr_en,
           txreg_reg_wr_en, cfg_done, busy, timeout_pulse
  );

  modport slave (
    output req_valid, req_data, req_last, txif, trmt,
    input  req_ready, grant, reg_data_out, spbrg_reg_wr_en, txsta_reg_wr_en,
           txreg_reg_wr_en, cfg_done, busy, timeout_pulse
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet round-robin arbiter feeding uart TXREG after an SPBRG/TXSTA setup; byte written the cycle txif&valid meet in WAIT,
// one HOLD cycle after; req_ready only to the grant while txif=1. Optional stall release: UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int         NUM_REQ        = 4,
  parameter logic [7:0] SPBRG_INIT     = 8'd25,
  parameter logic       BRGH_INIT      = 1'b1,
  parameter int         TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.master bus
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {CFG_BRG, CFG_TX, ARB, WAIT, HOLD} state_t;

  state_t             state, state_nxt;
  logic [IW-1:0]      rr_ptr, rr_ptr_nxt;
  logic [IW-1:0]      gidx, gidx_nxt;
  logic [NUM_REQ-1:0] grant_q, grant_nxt;
  logic               last_q, last_nxt;
  logic               cfg_done_q, cfg_done_nxt;
  logic               arb_found;
  logic [IW-1:0]      arb_idx;
  logic               sel_valid, sel_last, txfer, tmo;
  logic [7:0]         sel_data;

  function automatic logic [IW-1:0] wrap_idx(input int v);
    int m;
    m = v % NUM_REQ;
    return m[IW-1:0];
  endfunction

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!arb_found && bus.req_valid[wrap_idx(int'(rr_ptr) + off)]) begin
        arb_found = 1'b1;
        arb_idx   = wrap_idx(int'(rr_ptr) + off);
      end
    end
  end

  assign sel_valid = bus.req_valid[gidx];
  assign sel_last  = bus.req_last[gidx];
  assign sel_data  = bus.req_data[8*int'(gidx) +: 8];
  assign txfer     = (state == WAIT) && bus.txif && sel_valid;

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [15:0] stall_cnt;
  logic        stall;

  assign stall = (state == WAIT) && bus.txif && !sel_valid;
  // Fires on the stall cycle that brings the count up to TIMEOUT_CYCLES.
  assign tmo   = stall && (stall_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || state != WAIT || txfer || tmo) stall_cnt <= '0;
    else if (stall)                           stall_cnt <= stall_cnt + 16'd1;
  end

  assign bus.timeout_pulse = tmo && !rst;
`else
  assign tmo               = 1'b0;
  assign bus.timeout_pulse = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant_q;
    gidx_nxt     = gidx;
    rr_ptr_nxt   = rr_ptr;
    last_nxt     = last_q;
    cfg_done_nxt = cfg_done_q;
    unique case (state)
      CFG_BRG: state_nxt = CFG_TX;
      CFG_TX: begin
        state_nxt    = ARB;
        cfg_done_nxt = 1'b1;
      end
      ARB: begin
        if (arb_found) begin
          grant_nxt = {{(NUM_REQ-1){1'b0}}, 1'b1} << arb_idx;
          gidx_nxt  = arb_idx;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (txfer) begin
          last_nxt  = sel_last;
          state_nxt = HOLD;
        end else if (tmo) begin
          grant_nxt  = '0;
          rr_ptr_nxt = wrap_idx(int'(gidx) + 1);
          state_nxt  = ARB;
        end
      end
      HOLD: begin
        // txif is still stale high here; the uart drops it one cycle after the write.
        if (last_q) begin
          grant_nxt  = '0;
          rr_ptr_nxt = wrap_idx(int'(gidx) + 1);
          state_nxt  = ARB;
        end else begin
          state_nxt = WAIT;
        end
      end
      default: state_nxt = CFG_BRG;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CFG_BRG;
      grant_q    <= '0;
      gidx       <= '0;
      rr_ptr     <= '0;
      last_q     <= 1'b0;
      cfg_done_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant_q    <= grant_nxt;
      gidx       <= gidx_nxt;
      rr_ptr     <= rr_ptr_nxt;
      last_q     <= last_nxt;
      cfg_done_q <= cfg_done_nxt;
    end
  end

  always_comb begin
    bus.spbrg_reg_wr_en = 1'b0;
    bus.txsta_reg_wr_en = 1'b0;
    bus.txreg_reg_wr_en = 1'b0;
    bus.reg_data_out    = 8'h00;
    bus.req_ready       = '0;
    if (!rst) begin
      unique case (state)
        CFG_BRG: begin
          bus.spbrg_reg_wr_en = 1'b1;
          bus.reg_data_out    = SPBRG_INIT;
        end
        CFG_TX: begin
          bus.txsta_reg_wr_en = 1'b1;
          bus.reg_data_out    = {2'b00, 1'b1, 2'b00, BRGH_INIT, 2'b00};
        end
        WAIT: begin
          if (txfer) begin
            bus.txreg_reg_wr_en = 1'b1;
            bus.reg_data_out    = sel_data;
            bus.req_ready       = grant_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.grant    = rst ? '0 : grant_q;
  assign bus.cfg_done = cfg_done_q && !rst;
  assign bus.busy     = rst || (|grant_q) || !bus.trmt || !bus.txif;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queue-driven requesters, a small uart txif/trmt model, and per-scenario checks.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ = 4;
  localparam int TMO     = 10;
  localparam int BYTE_T  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .SPBRG_INIT(8'd25), .BRGH_INIT(1'b1), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [7:0]         q_data [NUM_REQ][$];
  logic               q_last [NUM_REQ][$];
  logic [NUM_REQ-1:0] hold_mask;
  int                 log_req [$];
  logic [7:0]         log_byte [$];
  logic [NUM_REQ-1:0] log_grant [$];

  logic               s_spbrg, s_txsta, s_wr, s_cfg, s_busy, s_pulse, s_txif;
  logic [7:0]         s_data;
  logic [NUM_REQ-1:0] s_grant, s_ready;

  // uart model: txif stays high the cycle after a write, then low for BYTE_T cycles
  logic pend;
  int   ucnt;
  always @(posedge clk) begin
    if (rst) begin
      bus.txif <= 1'b1;
      bus.trmt <= 1'b1;
      pend     <= 1'b0;
      ucnt     <= 0;
    end else begin
      if (bus.txreg_reg_wr_en) begin
        pend     <= 1'b1;
        bus.trmt <= 1'b0;
      end
      if (pend) begin
        pend     <= 1'b0;
        bus.txif <= 1'b0;
        ucnt     <= BYTE_T;
      end else if (!bus.txif) begin
        if (ucnt <= 1) begin
          bus.txif <= 1'b1;
          bus.trmt <= 1'b1;
        end else begin
          ucnt <= ucnt - 1;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  task automatic drive_reqs();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_valid[i]       = (q_data[i].size() > 0) && !hold_mask[i];
      bus.req_data[8*i +: 8] = (q_data[i].size() > 0) ? q_data[i][0] : 8'h00;
      bus.req_last[i]        = (q_last[i].size() > 0) ? q_last[i][0] : 1'b0;
    end
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < NUM_REQ; i++)
      if (q_data[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push(input int r, input logic [7:0] d, input logic l);
    q_data[r].push_back(d);
    q_last[r].push_back(l);
  endtask

  task automatic clear_log();
    log_req.delete();
    log_byte.delete();
    log_grant.delete();
  endtask

  // One clock: sample at negedge, apply accepted bytes just after the posedge.
  task automatic step_cycle();
    logic [1:0] nstb;
    int         idx;
    @(negedge clk);
    s_spbrg = bus.spbrg_reg_wr_en;
    s_txsta = bus.txsta_reg_wr_en;
    s_wr    = bus.txreg_reg_wr_en;
    s_data  = bus.reg_data_out;
    s_cfg   = bus.cfg_done;
    s_busy  = bus.busy;
    s_pulse = bus.timeout_pulse;
    s_txif  = bus.txif;
    s_grant = bus.grant;
    s_ready = bus.req_ready;
    nstb = 2'(s_spbrg) + 2'(s_txsta) + 2'(s_wr);
    n_chk++;
    if (nstb > 2'd1 || (nstb == 2'd0 && s_data != 8'h00) || ((s_ready & ~s_grant) != '0) ||
        (s_wr != (s_ready != '0)) || (s_wr && (!s_txif || pend))) begin
      n_err++;
      $display("FAIL protocol @%0t: strobes=%b%b%b data=%h ready=%b grant=%b txif=%b pend=%b, want one strobe, legal ready/write",
               $time, s_spbrg, s_txsta, s_wr, s_data, s_ready, s_grant, s_txif, pend);
    end
    if (s_wr) begin
      idx = -1;
      for (int i = 0; i < NUM_REQ; i++) if (s_ready[i]) idx = i;
      log_req.push_back(idx);
      log_byte.push_back(s_data);
      log_grant.push_back(s_grant);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (s_ready[i]) begin
        void'(q_data[i].pop_front());
        void'(q_last[i].pop_front());
      end
    end
    drive_reqs();
  endtask

  task automatic run_drain(input string name, input int max_cyc);
    int c;
    c = 0;
    do begin
      step_cycle();
      c++;
    end while (!(queues_empty() && s_grant == '0) && c < max_cyc);
    n_chk++;
    if (!(queues_empty() && s_grant == '0)) begin
      n_err++;
      $display("FAIL %s_drain: not idle after %0d cycles (grant=%b), want queues empty and grant 0", name, c, s_grant);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step_cycle();
    n_chk++; if (s_grant !== 4'b0000) begin n_err++; $display("FAIL rst_grant: got %b want 0000", s_grant); end
    n_chk++; if (s_ready !== 4'b0000) begin n_err++; $display("FAIL rst_ready: got %b want 0000", s_ready); end
    n_chk++; if ({s_spbrg, s_txsta, s_wr} !== 3'b000) begin n_err++; $display("FAIL rst_strobes: got %b want 000", {s_spbrg, s_txsta, s_wr}); end
    n_chk++; if (s_data !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h want 00", s_data); end
    n_chk++; if (s_cfg !== 1'b0 || s_pulse !== 1'b0) begin n_err++; $display("FAIL rst_cfg_tmo: got cfg=%b tmo=%b want 0 0", s_cfg, s_pulse); end
    n_chk++; if (s_busy !== 1'b1) begin n_err++; $display("FAIL rst_busy: got %b want 1", s_busy); end
    rst = 1'b0;
    step_cycle();
    n_chk++;
    if ({s_spbrg, s_txsta, s_wr} !== 3'b100 || s_data !== 8'h19) begin
      n_err++; $display("FAIL cfg_brg: got strobes=%b data=%h want 100 19", {s_spbrg, s_txsta, s_wr}, s_data);
    end
    step_cycle();
    n_chk++;
    if ({s_spbrg, s_txsta, s_wr} !== 3'b010 || s_data !== 8'h24) begin
      n_err++; $display("FAIL cfg_txsta: got strobes=%b data=%h want 010 24", {s_spbrg, s_txsta, s_wr}, s_data);
    end
    step_cycle();
    n_chk++;
    if (s_cfg !== 1'b1 || {s_spbrg, s_txsta, s_wr} !== 3'b000 || s_data !== 8'h00 || s_busy !== 1'b0) begin
      n_err++; $display("FAIL cfg_done: got cfg=%b strobes=%b data=%h busy=%b want 1 000 00 0",
                        s_cfg, {s_spbrg, s_txsta, s_wr}, s_data, s_busy);
    end
  endtask

  task automatic test_single_packet();
    logic [7:0] exp_b [3] = '{8'hA1, 8'hA2, 8'hA3};
    clear_log();
    push(0, 8'hA1, 1'b0); push(0, 8'hA2, 1'b0); push(0, 8'hA3, 1'b1);
    drive_reqs();
    run_drain("single", 200);
    n_chk++;
    if (log_byte.size() != 3) begin
      n_err++; $display("FAIL single_count: got %0d writes want 3", log_byte.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (log_req[k] != 0 || log_byte[k] !== exp_b[k] || log_grant[k] !== 4'b0001) begin
          n_err++; $display("FAIL single_byte[%0d]: got req%0d %h grant=%b want req0 %h grant=0001",
                            k, log_req[k], log_byte[k], log_grant[k], exp_b[k]);
        end
      end
    end
    n_chk++; if (s_grant !== 4'b0000) begin n_err++; $display("FAIL single_release: got grant %b want 0000", s_grant); end
  endtask

  task automatic test_round_robin();
    int         exp_r [6] = '{1, 1, 3, 3, 0, 1};
    logic [7:0] exp_b [6] = '{8'hB1, 8'hB2, 8'hC1, 8'hC2, 8'hD1, 8'hE1};
    clear_log();
    push(1, 8'hB1, 1'b0); push(1, 8'hB2, 1'b1); push(1, 8'hE1, 1'b1);
    push(3, 8'hC1, 1'b0); push(3, 8'hC2, 1'b1);
    push(0, 8'hD1, 1'b1);
    drive_reqs();
    run_drain("rr", 400);
    n_chk++;
    if (log_byte.size() != 6) begin
      n_err++; $display("FAIL rr_count: got %0d writes want 6", log_byte.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        n_chk++;
        if (log_req[k] != exp_r[k] || log_byte[k] !== exp_b[k]) begin
          n_err++; $display("FAIL rr_order[%0d]: got req%0d %h want req%0d %h", k, log_req[k], log_byte[k], exp_r[k], exp_b[k]);
        end
      end
    end
  endtask

  task automatic test_fairness();
    int         exp_r [8] = '{2, 2, 0, 0, 2, 2, 0, 0};
    logic [7:0] exp_b [8] = '{8'hF1, 8'hF2, 8'h71, 8'h72, 8'hF3, 8'hF4, 8'h73, 8'h74};
    clear_log();
    push(2, 8'hF1, 1'b0); push(2, 8'hF2, 1'b1); push(2, 8'hF3, 1'b0); push(2, 8'hF4, 1'b1);
    push(0, 8'h71, 1'b0); push(0, 8'h72, 1'b1); push(0, 8'h73, 1'b0); push(0, 8'h74, 1'b1);
    drive_reqs();
    run_drain("fair", 500);
    n_chk++;
    if (log_byte.size() != 8) begin
      n_err++; $display("FAIL fair_count: got %0d writes want 8", log_byte.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_chk++;
        if (log_req[k] != exp_r[k] || log_byte[k] !== exp_b[k]) begin
          n_err++; $display("FAIL fair_order[%0d]: got req%0d %h want req%0d %h", k, log_req[k], log_byte[k], exp_r[k], exp_b[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    int         c, early;
    logic [7:0] exp_b [3] = '{8'h81, 8'h82, 8'h83};
    clear_log();
    push(1, 8'h81, 1'b0); push(1, 8'h82, 1'b0); push(1, 8'h83, 1'b1);
    drive_reqs();
    c = 0;
    while (log_byte.size() < 1 && c < 100) begin step_cycle(); c++; end
    step_cycle();
    step_cycle();
    n_chk++; if (s_grant !== 4'b0010) begin n_err++; $display("FAIL midrst_held: got grant %b want 0010", s_grant); end
    rst = 1'b1;
    step_cycle();
    step_cycle();
    n_chk++;
    if (s_grant !== 4'b0000 || s_ready !== 4'b0000) begin
      n_err++; $display("FAIL midrst_drop: got grant=%b ready=%b want 0000 0000", s_grant, s_ready);
    end
    rst = 1'b0;
    step_cycle();
    n_chk++; if (s_spbrg !== 1'b1) begin n_err++; $display("FAIL midrst_recfg: got spbrg_wr=%b want 1", s_spbrg); end
    c = 1; early = 0;
    while (s_cfg !== 1'b1 && c < 10) begin
      step_cycle(); c++;
      if (s_wr && s_cfg !== 1'b1) early++;
    end
    n_chk++;
    if (early != 0 || c != 3) begin
      n_err++; $display("FAIL midrst_cfg: got %0d early writes, cfg_done after %0d cycles want 0 and 3", early, c);
    end
    run_drain("midrst", 200);
    n_chk++;
    if (log_byte.size() != 3) begin
      n_err++; $display("FAIL midrst_count: got %0d writes want 3", log_byte.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (log_req[k] != 1 || log_byte[k] !== exp_b[k]) begin
          n_err++; $display("FAIL midrst_byte[%0d]: got req%0d %h want req1 %h", k, log_req[k], log_byte[k], exp_b[k]);
        end
      end
    end
  endtask

  task automatic test_stall();
    int c;
`ifdef UART_TX_ARB_TIMEOUT_EN
    int         exp_r [4] = '{0, 1, 0, 0};
    logic [7:0] exp_b [4] = '{8'h61, 8'h51, 8'h62, 8'h63};
`else
    int         exp_r [4] = '{0, 0, 0, 1};
    logic [7:0] exp_b [4] = '{8'h61, 8'h62, 8'h63, 8'h51};
    int         bad;
`endif
    clear_log();
    push(0, 8'h61, 1'b0); push(0, 8'h62, 1'b0); push(0, 8'h63, 1'b1);
    push(1, 8'h51, 1'b1);
    drive_reqs();
    c = 0;
    while (log_byte.size() < 1 && c < 100) begin step_cycle(); c++; end
    hold_mask = 4'b0001;
    drive_reqs();
`ifdef UART_TX_ARB_TIMEOUT_EN
    step_cycle();
    c = 0;
    do begin
      step_cycle();
      if (s_txif) c++;
    end while (!s_pulse && c < 100);
    n_chk++;
    if (s_pulse !== 1'b1 || c != TMO || s_grant !== 4'b0001) begin
      n_err++; $display("FAIL tmo_fire: got pulse=%b after %0d stall cycles grant=%b want 1 after %0d grant=0001",
                        s_pulse, c, s_grant, TMO);
    end
    hold_mask = 4'b0000;
    drive_reqs();
    step_cycle();
    n_chk++; if (s_pulse !== 1'b0) begin n_err++; $display("FAIL tmo_width: got pulse=%b want 0", s_pulse); end
    step_cycle();
    n_chk++; if (s_grant !== 4'b0010) begin n_err++; $display("FAIL tmo_next: got grant %b want 0010", s_grant); end
`else
    bad = 0;
    repeat (30) begin
      step_cycle();
      if (s_grant !== 4'b0001 || s_pulse !== 1'b0 || s_wr) bad++;
    end
    n_chk++;
    if (bad != 0) begin n_err++; $display("FAIL stall_hold: got %0d cycles losing grant/pulsing/writing want 0", bad); end
    hold_mask = 4'b0000;
    drive_reqs();
`endif
    run_drain("stall", 300);
    n_chk++;
    if (log_byte.size() != 4) begin
      n_err++; $display("FAIL stall_count: got %0d writes want 4", log_byte.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_chk++;
        if (log_req[k] != exp_r[k] || log_byte[k] !== exp_b[k]) begin
          n_err++; $display("FAIL stall_order[%0d]: got req%0d %h want req%0d %h", k, log_req[k], log_byte[k], exp_r[k], exp_b[k]);
        end
      end
    end
  endtask

  initial begin
    hold_mask = '0;
    drive_reqs();
    test_reset();
    test_single_packet();
    test_round_robin();
    test_fairness();
    test_reset_mid_packet();
    test_stall();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
